// File: rtl/mux_nx1_rr.sv
// mux_nx1_rr: N:1 valid/ready channel mux, registered output; round-robin mode only with `MUX_NX1_RR_EN.
// Latency: a word accepted at one edge is on out_data/out_valid after that edge; one word per cycle sustained.
// Backpressure: while out_valid && !out_ready the output register holds and every in_ready is low.
module mux_nx1_rr #(
  parameter int N = 4,
  parameter int W = 8,
  localparam int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]  in_valid,
  output logic [N-1:0]  in_ready,
  input  logic          mode,
  input  logic [SW-1:0] sel,
  output logic [W-1:0]  out_data,
  output logic [SW-1:0] out_ch,
  output logic          out_valid,
  input  logic          out_ready
);

  logic          load_en;
  logic          have_grant;
  logic [SW-1:0] grant;
  logic          dir_ok;

  assign load_en = !out_valid || out_ready;
  assign dir_ok  = (int'(sel) < N) && in_valid[sel];

`ifdef MUX_NX1_RR_EN
  logic [SW-1:0] rr_ptr;
  logic [SW-1:0] rr_grant;
  logic          rr_found;

  // First valid channel at or after rr_ptr, wrapping past N-1 back to 0.
  always_comb begin
    rr_grant = rr_ptr;
    rr_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!rr_found && in_valid[(int'(rr_ptr) + k) % N]) begin
        rr_found = 1'b1;
        rr_grant = SW'((int'(rr_ptr) + k) % N);
      end
    end
  end

  assign grant      = mode ? rr_grant : sel;
  assign have_grant = mode ? rr_found : dir_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (mode && load_en && have_grant) begin
      rr_ptr <= (int'(grant) == N - 1) ? '0 : grant + SW'(1);
    end
  end
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign grant       = sel;
  assign have_grant  = dir_ok;
`endif

  // Gated by rst_n so no handshake completes while the register is being cleared.
  always_comb begin
    in_ready = '0;
    if (rst_n && load_en && have_grant) begin
      in_ready[grant] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (load_en) begin
      out_valid <= have_grant;
      if (have_grant) begin
        out_data <= in_data[int'(grant)*W +: W];
        out_ch   <= grant;
      end
    end
  end

endmodule

// File: tb/tb_mux_nx1_rr.sv
// Directed bench for mux_nx1_rr (N=4, W=8); round-robin steps only when MUX_NX1_RR_EN is defined.
module tb_mux_nx1_rr;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 2;

  logic          clk;
  logic          rst_n;
  logic [N*W-1:0] in_data;
  logic [N-1:0]  in_valid;
  logic [N-1:0]  in_ready;
  logic          mode;
  logic [SW-1:0] sel;
  logic [W-1:0]  out_data;
  logic [SW-1:0] out_ch;
  logic          out_valid;
  logic          out_ready;

  int passed = 0;
  int total  = 0;

  mux_nx1_rr #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [W-1:0] d, input logic [SW-1:0] c);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".data"},  32'(out_data),  32'(d));
    chk({tag, ".ch"},    32'(out_ch),    32'(c));
  endtask

  initial begin
    rst_n     = 1'b0;
    in_data   = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
    in_valid  = 4'hF;
    out_ready = 1'b0;
    mode      = 1'b0;
    sel       = 2'd2;
    #2;
    chk_out("reset", 1'b0, 8'h00, 2'd0);
    chk("reset.in_ready", 32'(in_ready), 32'h0);

    // Direct select, back-to-back words with no bubble.
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("dir.ready_sel2", 32'(in_ready), 32'b0100);
    tick;
    chk_out("dir.sel2", 1'b1, 8'hCC, 2'd2);
    sel = 2'd3;
    #1;
    chk("dir.ready_sel3", 32'(in_ready), 32'b1000);
    tick;
    chk_out("dir.sel3", 1'b1, 8'hDD, 2'd3);

    // Selected channel not valid: register drains and goes empty, data/ch hold.
    sel      = 2'd1;
    in_valid = 4'b1101;
    #1;
    chk("dir.noval_ready", 32'(in_ready), 32'h0);
    tick;
    chk_out("dir.noval", 1'b0, 8'hDD, 2'd3);

    // Backpressure: load AA, then stall three cycles while sel changes underneath.
    in_valid  = 4'hF;
    sel       = 2'd0;
    out_ready = 1'b0;
    #1;
    chk("bp.ready_empty", 32'(in_ready), 32'b0001);
    tick;
    chk_out("bp.load", 1'b1, 8'hAA, 2'd0);
    sel = 2'd2;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp.ready_stall", 32'(in_ready), 32'h0);
      tick;
      chk_out("bp.stall", 1'b1, 8'hAA, 2'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp.ready_release", 32'(in_ready), 32'b0100);
    tick;
    chk_out("bp.release", 1'b1, 8'hCC, 2'd2);

    // Asynchronous reset mid-stream with a word held.
    #3;
    rst_n    = 1'b0;
    in_valid = 4'h0;
    #1;
    chk_out("arst", 1'b0, 8'h00, 2'd0);
    chk("arst.in_ready", 32'(in_ready), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef MUX_NX1_RR_EN
    // Fairness with all channels valid.
    mode     = 1'b1;
    in_valid = 4'hF;
    for (int i = 0; i < 8; i++) begin
      tick;
      chk("rr.all_ch", 32'(out_ch), 32'(i % 4));
    end
    // Sparse requests from rr_ptr = 0.
    in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("rr.sparse_ch",   32'(out_ch),   (i % 2 == 0) ? 32'd1 : 32'd3);
      chk("rr.sparse_data", 32'(out_data), (i % 2 == 0) ? 32'hBB : 32'hDD);
    end
    // A direct-mode transfer must not move the pointer (still 0).
    mode     = 1'b0;
    sel      = 2'd2;
    in_valid = 4'hF;
    tick;
    chk("rr.direct_ch", 32'(out_ch), 32'd2);
    mode = 1'b1;
    tick;
    chk("rr.ptr_kept_ch", 32'(out_ch), 32'd0);
    tick;
    chk("rr.ptr_next_ch", 32'(out_ch), 32'd1);
`else
    // Round-robin compiled out: mode is ignored.
    mode     = 1'b1;
    sel      = 2'd1;
    in_valid = 4'hF;
    #1;
    chk("nrr.ready", 32'(in_ready), 32'b0010);
    tick;
    chk_out("nrr.sel1", 1'b1, 8'hBB, 2'd1);
    in_valid = 4'b1101;
    #1;
    chk("nrr.noval_ready", 32'(in_ready), 32'h0);
    tick;
    chk_out("nrr.noval", 1'b0, 8'hBB, 2'd1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
